// File: rtl/shift_sched_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : clk_rstn_intrf                                         |
// | Description : Clock / reset bundle shared by the FFT datapath blocks.|
// |               The master side drives clk and rst (asynchronous,      |
// |               active-high); consumers attach through the slave side. |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
interface clk_rstn_intrf;
   logic clk;
   logic rst;

   modport master (output clk, output rst);
   modport slave  (input  clk, input  rst);
endinterface : clk_rstn_intrf
`default_nettype wire

// File: rtl/shift_sched.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : shift_sched                                            |
// | Description : Per-stage scaling scheduler for the in-place FFT       |
// |               datapath. Drives the shift unit's shamt for each       |
// |               butterfly stage, watches every stage's output samples  |
// |               to choose the next stage's shift (fixed 1/2 scaling or |
// |               block floating point) and keeps the running block      |
// |               exponent of the transform.                             |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module shift_sched #(
   parameter int width     = 8,
   parameter int shamtbits = 4,
   parameter int nlog2     = 3,
   parameter int expbits   = 6
) (
   clk_rstn_intrf.slave            clk_rstn_i,
   input  logic                    start_i,
   input  logic                    mode_i,
   input  logic                    smp_valid_i,
   input  logic [width-1:0]        smp_data_i,
   input  logic                    smp_last_i,
   output logic [shamtbits-1:0]    shamt_o,
   output logic                    shamt_valid_o,
   output logic [$clog2(nlog2):0]  stage_o,
   output logic [expbits-1:0]      exp_o,
   output logic                    busy_o,
   output logic                    done_o,
   output logic                    ovf_o
);

   // ------------------------------------------------------------------
   // Elaboration-time parameter sanity
   // ------------------------------------------------------------------
   generate
      if ((width != 8) && (width != 16)) begin : g_bad_width
         $error("shift_sched: width must be 8 or 16");
      end
      if (shamtbits != ((width == 16) ? 5 : 4)) begin : g_bad_shamtbits
         $error("shift_sched: shamtbits must be 4 for width 8, 5 for width 16");
      end
      if (expbits < 2) begin : g_bad_expbits
         $error("shift_sched: expbits must be at least 2");
      end
   endgenerate

   // ------------------------------------------------------------------
   // Constants
   // ------------------------------------------------------------------
   // Headroom never exceeds width-1, so $clog2(width) bits hold it.
   localparam int c_hw = $clog2(width);
   localparam int c_sw = $clog2(nlog2) + 1;
   // Exponent arithmetic is done wide enough that exp +/- (width-2)
   // can never wrap before the saturation compare.
   localparam int c_xw = expbits + 6;

   localparam logic [c_hw-1:0]      c_hr_full     = c_hw'(width - 1);
   localparam logic [c_hw-1:0]      c_k_max       = c_hw'(width - 2);
   localparam logic [c_sw-1:0]      c_stage_last  = c_sw'(nlog2 - 1);
   localparam logic [shamtbits-1:0] c_shamt_right = {1'b1, {(shamtbits-1){1'b0}}};
   localparam logic [expbits-1:0]   c_exp_one     = expbits'(1);
   localparam logic signed [c_xw-1:0] c_exp_max   = c_xw'((1 << (expbits - 1)) - 1);
   localparam logic signed [c_xw-1:0] c_exp_min   = c_xw'(-(1 << (expbits - 1)));

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_EVAL = 2'd2,
      ST_DONE = 2'd3
   } state_t;

   // ------------------------------------------------------------------
   // State and output registers with their next-state values
   // ------------------------------------------------------------------
   state_t                 r_state,  w_state_nxt;
   logic                   r_mode,   w_mode_nxt;
   logic [c_hw-1:0]        r_minhr,  w_minhr_nxt;
   logic [shamtbits-1:0]   r_shamt,  w_shamt_nxt;
   logic                   r_shv,    w_shv_nxt;
   logic [c_sw-1:0]        r_stage,  w_stage_nxt;
   logic [expbits-1:0]     r_exp,    w_exp_nxt;
   logic                   r_busy,   w_busy_nxt;
   logic                   r_done,   w_done_nxt;
   logic                   r_ovf,    w_ovf_nxt;

   // Datapath helpers
   logic [c_hw-1:0]        w_smp_hr;
   logic                   w_hr_run;
   logic [c_hw-1:0]        w_k;
   logic [shamtbits-1:0]   w_eval_shamt;
   logic signed [c_xw-1:0] w_eval_delta;
   logic signed [c_xw-1:0] w_exp_sum;
   logic [expbits-1:0]     w_exp_sat;
   logic                   w_exp_sat_ovf;

   // Headroom of the incoming sample: length of the run of bits below the
   // sign bit that still equal the sign bit (0 and -1 give width-1).
   always_comb begin
      w_smp_hr = '0;
      w_hr_run = 1'b1;
      for (int i = width - 2; i >= 0; i--) begin
         if (w_hr_run && (smp_data_i[i] == smp_data_i[width-1])) begin
            w_smp_hr = w_smp_hr + c_hw'(1);
         end else begin
            w_hr_run = 1'b0;
         end
      end
   end

   // Shift choice for the next stage from the finished stage's minimum
   // headroom: no headroom forces a right shift, one bit of headroom is
   // kept as margin for butterfly growth, anything more is used up by a
   // left shift.
   always_comb begin
      w_k = r_minhr - c_hw'(1);
      if (w_k > c_k_max) begin
         w_k = c_k_max;
      end
      w_eval_shamt = c_shamt_right;
      w_eval_delta = c_xw'(1);
      if (r_mode && (r_minhr != '0)) begin
         if (r_minhr == c_hw'(1)) begin
            w_eval_shamt = '0;
            w_eval_delta = '0;
         end else begin
            w_eval_shamt = {1'b0, (shamtbits-1)'(w_k)};
            w_eval_delta = c_xw'(0) - c_xw'(w_k);
         end
      end
   end

   // Saturating exponent update; flags when the clamp actually engaged.
   always_comb begin
      w_exp_sum     = $signed({{(c_xw-expbits){r_exp[expbits-1]}}, r_exp}) + w_eval_delta;
      w_exp_sat     = w_exp_sum[expbits-1:0];
      w_exp_sat_ovf = 1'b0;
      if (w_exp_sum > c_exp_max) begin
         w_exp_sat     = c_exp_max[expbits-1:0];
         w_exp_sat_ovf = 1'b1;
      end else if (w_exp_sum < c_exp_min) begin
         w_exp_sat     = c_exp_min[expbits-1:0];
         w_exp_sat_ovf = 1'b1;
      end
   end

   // Sequencer next-state and next-output logic.
   always_comb begin
      w_state_nxt = r_state;
      w_mode_nxt  = r_mode;
      w_minhr_nxt = r_minhr;
      w_shamt_nxt = r_shamt;
      w_shv_nxt   = r_shv;
      w_stage_nxt = r_stage;
      w_exp_nxt   = r_exp;
      w_busy_nxt  = r_busy;
      w_done_nxt  = 1'b0;
      w_ovf_nxt   = r_ovf;

      case (r_state)
         ST_IDLE: begin
            if (start_i) begin
               w_state_nxt = ST_RUN;
               w_mode_nxt  = mode_i;
               w_minhr_nxt = c_hr_full;
               w_shv_nxt   = 1'b1;
               w_stage_nxt = '0;
               w_busy_nxt  = 1'b1;
               w_ovf_nxt   = 1'b0;
               if (mode_i) begin
                  w_shamt_nxt = '0;
                  w_exp_nxt   = '0;
               end else begin
                  w_shamt_nxt = c_shamt_right;
                  w_exp_nxt   = c_exp_one;
               end
            end
         end

         ST_RUN: begin
            if (smp_valid_i) begin
               if (w_smp_hr < r_minhr) begin
                  w_minhr_nxt = w_smp_hr;
               end
               if (smp_last_i) begin
                  w_shv_nxt   = 1'b0;
                  w_state_nxt = (r_stage == c_stage_last) ? ST_DONE : ST_EVAL;
               end
            end
         end

         ST_EVAL: begin
            w_state_nxt = ST_RUN;
            w_stage_nxt = r_stage + c_sw'(1);
            w_shv_nxt   = 1'b1;
            w_minhr_nxt = c_hr_full;
            w_shamt_nxt = w_eval_shamt;
            w_exp_nxt   = w_exp_sat;
            if (w_exp_sat_ovf) begin
               w_ovf_nxt = 1'b1;
            end
         end

         ST_DONE: begin
            w_state_nxt = ST_IDLE;
            w_done_nxt  = 1'b1;
            w_busy_nxt  = 1'b0;
            w_shv_nxt   = 1'b0;
         end

         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   // State and output registers; reset aborts any transform immediately.
   always_ff @(posedge clk_rstn_i.clk or posedge clk_rstn_i.rst) begin
      if (clk_rstn_i.rst) begin
         r_state <= ST_IDLE;
         r_mode  <= 1'b0;
         r_minhr <= c_hr_full;
         r_shamt <= '0;
         r_shv   <= 1'b0;
         r_stage <= '0;
         r_exp   <= '0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
         r_ovf   <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_mode  <= w_mode_nxt;
         r_minhr <= w_minhr_nxt;
         r_shamt <= w_shamt_nxt;
         r_shv   <= w_shv_nxt;
         r_stage <= w_stage_nxt;
         r_exp   <= w_exp_nxt;
         r_busy  <= w_busy_nxt;
         r_done  <= w_done_nxt;
         r_ovf   <= w_ovf_nxt;
      end
   end

   assign shamt_o       = r_shamt;
   assign shamt_valid_o = r_shv;
   assign stage_o       = r_stage;
   assign exp_o         = r_exp;
   assign busy_o        = r_busy;
   assign done_o        = r_done;
   assign ovf_o         = r_ovf;

endmodule : shift_sched
`default_nettype wire

// File: tb/tb_shift_sched.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : tb_shift_sched                                         |
// | Description : Self-checking bench for shift_sched. Two instances:    |
// |               A (expbits 6, 3 stages) and B (expbits 3, 4 stages).   |
// |               A transform-level model predicts every output each     |
// |               cycle; directed literal checks pin the model.          |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module tb_shift_sched;

   localparam int W  = 8;
   localparam int NA = 3;
   localparam int EA = 6;
   localparam int NB = 4;
   localparam int EB = 3;
   localparam int SH_RIGHT = 8;   // 4'b1000: arithmetic right by one

   localparam int P_IDLE = 0;
   localparam int P_RUN  = 1;
   localparam int P_EVAL = 2;
   localparam int P_DONE = 3;

   logic clk = 1'b0;
   logic rst = 1'b1;

   logic         start_s [2];
   logic         mode_s  [2];
   logic         sv_s    [2];
   logic         sl_s    [2];
   logic [W-1:0] sd_s    [2];

   logic [3:0] shamt_a, shamt_b;
   logic       shv_a,   shv_b;
   logic [2:0] stage_a, stage_b;
   logic [EA-1:0] exp_a;
   logic [EB-1:0] exp_b;
   logic       busy_a, busy_b, done_a, done_b, ovf_a, ovf_b;

   int n_tests = 0;
   int n_fail  = 0;

   // transform-level model state, one slot per instance
   int m_ph [2], m_stage [2], m_exp [2], m_hmin [2], m_shamt [2];
   int m_shv [2], m_busy [2], m_done [2], m_ovf [2], m_mode [2];

   clk_rstn_intrf ifa ();
   clk_rstn_intrf ifb ();
   assign ifa.clk = clk;
   assign ifa.rst = rst;
   assign ifb.clk = clk;
   assign ifb.rst = rst;

   always #5 clk = ~clk;

   shift_sched #(.width(W), .shamtbits(4), .nlog2(NA), .expbits(EA)) u_dut_a (
      .clk_rstn_i    (ifa),
      .start_i       (start_s[0]),
      .mode_i        (mode_s[0]),
      .smp_valid_i   (sv_s[0]),
      .smp_data_i    (sd_s[0]),
      .smp_last_i    (sl_s[0]),
      .shamt_o       (shamt_a),
      .shamt_valid_o (shv_a),
      .stage_o       (stage_a),
      .exp_o         (exp_a),
      .busy_o        (busy_a),
      .done_o        (done_a),
      .ovf_o         (ovf_a)
   );

   shift_sched #(.width(W), .shamtbits(4), .nlog2(NB), .expbits(EB)) u_dut_b (
      .clk_rstn_i    (ifb),
      .start_i       (start_s[1]),
      .mode_i        (mode_s[1]),
      .smp_valid_i   (sv_s[1]),
      .smp_data_i    (sd_s[1]),
      .smp_last_i    (sl_s[1]),
      .shamt_o       (shamt_b),
      .shamt_valid_o (shv_b),
      .stage_o       (stage_b),
      .exp_o         (exp_b),
      .busy_o        (busy_b),
      .done_o        (done_b),
      .ovf_o         (ovf_b)
   );

   task automatic chk(input string nm, input int act, input int req);
      n_tests++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, req, $time);
      end
   endtask

   // Headroom as "spare sign bits": width minus the fewest two's-complement
   // bits that still represent the value.
   function automatic int headroom(input logic [W-1:0] s);
      int v;
      int nbits;
      v     = int'($signed(s));
      nbits = 1;
      while (!((v >= -(1 << (nbits - 1))) && (v < (1 << (nbits - 1)))))
         nbits++;
      return W - nbits;
   endfunction

   task automatic model_reset(input int id);
      m_ph[id] = P_IDLE;  m_stage[id] = 0; m_exp[id] = 0; m_hmin[id] = W - 1;
      m_shamt[id] = 0;    m_shv[id] = 0;   m_busy[id] = 0; m_done[id] = 0;
      m_ovf[id] = 0;      m_mode[id] = 0;
   endtask

   task automatic model_step(input int id);
      int nl;
      int eb;
      int emax;
      int emin;
      int h;
      int k;
      int delta;
      int e;
      nl   = (id != 0) ? NB : NA;
      eb   = (id != 0) ? EB : EA;
      emax = (1 << (eb - 1)) - 1;
      emin = -(1 << (eb - 1));
      m_done[id] = 0;
      if (m_ph[id] == P_IDLE) begin
         if (start_s[id]) begin
            m_ph[id] = P_RUN; m_busy[id] = 1; m_stage[id] = 0; m_ovf[id] = 0;
            m_shv[id] = 1; m_hmin[id] = W - 1; m_mode[id] = int'(mode_s[id]);
            m_shamt[id] = mode_s[id] ? 0 : SH_RIGHT;
            m_exp[id]   = mode_s[id] ? 0 : 1;
         end
      end else if (m_ph[id] == P_RUN) begin
         if (sv_s[id]) begin
            h = headroom(sd_s[id]);
            if (h < m_hmin[id]) m_hmin[id] = h;
            if (sl_s[id]) begin
               m_shv[id] = 0;
               m_ph[id]  = (m_stage[id] == nl - 1) ? P_DONE : P_EVAL;
            end
         end
      end else if (m_ph[id] == P_EVAL) begin
         m_stage[id]++;
         m_shv[id] = 1;
         if (m_mode[id] == 0 || m_hmin[id] == 0) begin
            delta = 1;  m_shamt[id] = SH_RIGHT;
         end else if (m_hmin[id] == 1) begin
            delta = 0;  m_shamt[id] = 0;
         end else begin
            k = m_hmin[id] - 1;
            if (k > W - 2) k = W - 2;
            delta = -k; m_shamt[id] = k;
         end
         e = m_exp[id] + delta;
         if (e > emax) begin
            e = emax; m_ovf[id] = 1;
         end else if (e < emin) begin
            e = emin; m_ovf[id] = 1;
         end
         m_exp[id]  = e;
         m_hmin[id] = W - 1;
         m_ph[id]   = P_RUN;
      end else begin
         m_done[id] = 1; m_busy[id] = 0; m_shv[id] = 0; m_ph[id] = P_IDLE;
      end
   endtask

   // model advances on the same events as the design
   initial begin
      model_reset(0);
      model_reset(1);
      forever begin
         @(posedge clk or posedge rst);
         if (rst) begin
            model_reset(0);
            model_reset(1);
         end else begin
            model_step(0);
            model_step(1);
         end
      end
   end

   // every-cycle comparison against the model, away from the active edge
   initial begin
      forever begin
         @(negedge clk);
         chk("a_shamt", int'(shamt_a), m_shamt[0]);
         chk("a_shv",   int'(shv_a),   m_shv[0]);
         chk("a_stage", int'(stage_a), m_stage[0]);
         chk("a_exp",   int'($signed(exp_a)), m_exp[0]);
         chk("a_busy",  int'(busy_a),  m_busy[0]);
         chk("a_done",  int'(done_a),  m_done[0]);
         chk("a_ovf",   int'(ovf_a),   m_ovf[0]);
         chk("b_shamt", int'(shamt_b), m_shamt[1]);
         chk("b_shv",   int'(shv_b),   m_shv[1]);
         chk("b_stage", int'(stage_b), m_stage[1]);
         chk("b_exp",   int'($signed(exp_b)), m_exp[1]);
         chk("b_busy",  int'(busy_b),  m_busy[1]);
         chk("b_done",  int'(done_b),  m_done[1]);
         chk("b_ovf",   int'(ovf_b),   m_ovf[1]);
      end
   end

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic do_start(input int id, input logic md);
      start_s[id] = 1'b1; mode_s[id] = md;
      @(negedge clk);
      start_s[id] = 1'b0; mode_s[id] = 1'b0;
   endtask

   task automatic send(input int id, input logic [W-1:0] d, input logic last);
      sv_s[id] = 1'b1; sd_s[id] = d; sl_s[id] = last;
      @(negedge clk);
      sv_s[id] = 1'b0; sd_s[id] = '0; sl_s[id] = 1'b0;
   endtask

   // Eight samples, last on the eighth, then the one-cycle evaluation gap.
   // peak and its negation are embedded among small background values.
   task automatic send_stage(input int id, input logic [W-1:0] peak, input logic allzero);
      logic [W-1:0] d;
      for (int i = 0; i < 8; i++) begin
         if (allzero)     d = '0;
         else if (i == 2) d = peak;
         else if (i == 5) d = W'(0) - peak;
         else             d = W'(i % 3) - W'(1);
         send(id, d, i == 7);
      end
      cyc(1);
   endtask

   initial begin
      for (int i = 0; i < 2; i++) begin
         start_s[i] = 1'b0; mode_s[i] = 1'b0; sv_s[i] = 1'b0;
         sl_s[i] = 1'b0; sd_s[i] = '0;
      end
      cyc(3);
      chk("lit_rst_busy", int'(busy_a), 0);
      chk("lit_rst_shv",  int'(shv_a),  0);
      chk("lit_rst_exp",  int'($signed(exp_a)), 0);
      rst = 1'b0;
      cyc(1);

      // fixed scaling: right by one every stage
      do_start(0, 1'b0);
      chk("lit_fix_shamt0", int'(shamt_a), 8);
      chk("lit_fix_exp0",   int'($signed(exp_a)), 1);
      chk("lit_fix_stage0", int'(stage_a), 0);
      send_stage(0, 8'h7F, 1'b0);
      chk("lit_fix_stage1", int'(stage_a), 1);
      chk("lit_fix_shamt1", int'(shamt_a), 8);
      send_stage(0, 8'h04, 1'b0);
      chk("lit_fix_exp2",   int'($signed(exp_a)), 3);
      send_stage(0, 8'h00, 1'b1);
      chk("lit_fix_done",   int'(done_a), 1);
      chk("lit_fix_expend", int'($signed(exp_a)), 3);
      chk("lit_fix_busy",   int'(busy_a), 0);
      cyc(1);
      chk("lit_fix_done_pulse", int'(done_a), 0);

      // BFP: full-scale sample forces right shift; headroom 1 holds
      do_start(0, 1'b1);
      chk("lit_bfp_shamt0", int'(shamt_a), 0);
      send_stage(0, 8'h7F, 1'b0);
      chk("lit_bfp_h0_shamt", int'(shamt_a), 8);
      chk("lit_bfp_h0_exp",   int'($signed(exp_a)), 1);
      send_stage(0, 8'h30, 1'b0);
      chk("lit_bfp_h1_shamt", int'(shamt_a), 0);
      chk("lit_bfp_h1_exp",   int'($signed(exp_a)), 1);
      send_stage(0, 8'h00, 1'b1);

      // BFP: headroom 4 -> left 3; all-zero -> left 6
      do_start(0, 1'b1);
      send_stage(0, 8'h04, 1'b0);
      chk("lit_bfp_h4_shamt", int'(shamt_a), 3);
      chk("lit_bfp_h4_exp",   int'($signed(exp_a)), -3);
      send_stage(0, 8'h00, 1'b1);
      chk("lit_bfp_h7_exp",   int'($signed(exp_a)), -9);
      send_stage(0, 8'h7F, 1'b0);
      do_start(0, 1'b1);
      send_stage(0, 8'h00, 1'b1);
      chk("lit_bfp_zero_shamt", int'(shamt_a), 6);
      chk("lit_bfp_zero_exp",   int'($signed(exp_a)), -6);

      // ignored inputs: start while busy, last without valid, valid in idle
      start_s[0] = 1'b1; mode_s[0] = 1'b0;
      cyc(1);
      start_s[0] = 1'b0;
      chk("lit_ign_start_stage", int'(stage_a), 1);
      chk("lit_ign_start_exp",   int'($signed(exp_a)), -6);
      sl_s[0] = 1'b1;
      cyc(1);
      sl_s[0] = 1'b0;
      chk("lit_ign_last_shv", int'(shv_a), 1);
      send_stage(0, 8'h7F, 1'b0);
      send_stage(0, 8'h00, 1'b1);
      send(0, 8'h7F, 1'b1);
      chk("lit_ign_idle_busy", int'(busy_a), 0);
      chk("lit_ign_idle_exp",  int'($signed(exp_a)), -5);

      // reset in the middle of stage 1
      do_start(0, 1'b1);
      send_stage(0, 8'h00, 1'b1);
      send(0, 8'h10, 1'b0);
      send(0, 8'h10, 1'b0);
      #2 rst = 1'b1;
      @(negedge clk);
      chk("lit_mid_rst_busy",  int'(busy_a),  0);
      chk("lit_mid_rst_stage", int'(stage_a), 0);
      chk("lit_mid_rst_shamt", int'(shamt_a), 0);
      rst = 1'b0;
      cyc(1);
      do_start(0, 1'b0);
      chk("lit_post_rst_shamt", int'(shamt_a), 8);
      send_stage(0, 8'h20, 1'b0);
      send_stage(0, 8'h20, 1'b0);
      send_stage(0, 8'h20, 1'b0);
      chk("lit_post_rst_exp", int'($signed(exp_a)), 3);

      // narrow exponent: clamps at -4 and +3, sticky overflow
      do_start(1, 1'b1);
      send_stage(1, 8'h00, 1'b1);
      chk("lit_sat_neg_exp", int'($signed(exp_b)), -4);
      chk("lit_sat_neg_ovf", int'(ovf_b), 1);
      send_stage(1, 8'h00, 1'b1);
      send_stage(1, 8'h00, 1'b1);
      send_stage(1, 8'h7F, 1'b0);
      chk("lit_sat_done", int'(done_b), 1);
      cyc(2);
      chk("lit_sat_sticky", int'(ovf_b), 1);
      do_start(1, 1'b0);
      chk("lit_sat_clear", int'(ovf_b), 0);
      send_stage(1, 8'h00, 1'b0);
      send_stage(1, 8'h00, 1'b0);
      send_stage(1, 8'h00, 1'b0);
      chk("lit_sat_pos_exp", int'($signed(exp_b)), 3);
      chk("lit_sat_pos_ovf", int'(ovf_b), 1);
      send_stage(1, 8'h00, 1'b0);
      cyc(2);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog expired");
   end

endmodule : tb_shift_sched
`default_nettype wire
